// File: rtl/neighbor_dist_calc_if.sv
// neighbor_dist_calc_if: FIFO, query, result and status signals of the neighbor distance stage.
// Best-result outputs exist only when NEIGHBOR_BEST_TRACK_EN is defined.
interface neighbor_dist_calc_if #(
    parameter int DIST_W = 64
);
    logic              start_in;
    logic [31:0]       query_in;
    logic              query_valid_in;
    logic [31:0]       neigh_in;
    logic              neigh_valid_in;
    logic              neigh_deq_out;
    logic [31:0]       pos_in;
    logic              pos_valid_in;
    logic              pos_deq_out;
    logic              reached_end_in;
    logic [31:0]       id_out;
    logic [DIST_W-1:0] dist_out;
    logic              result_valid_out;
    logic              result_ready_in;
    logic              busy_out;
    logic              done_out;
`ifdef NEIGHBOR_BEST_TRACK_EN
    logic [31:0]       best_id_out;
    logic [DIST_W-1:0] best_dist_out;
    logic              best_valid_out;
`endif

    modport slave (
        input  start_in, query_in, query_valid_in, neigh_in, neigh_valid_in,
        input  pos_in, pos_valid_in, reached_end_in, result_ready_in,
        output neigh_deq_out, pos_deq_out, id_out, dist_out, result_valid_out,
        output busy_out, done_out
`ifdef NEIGHBOR_BEST_TRACK_EN
        , output best_id_out, best_dist_out, best_valid_out
`endif
    );

    modport master (
        output start_in, query_in, query_valid_in, neigh_in, neigh_valid_in,
        output pos_in, pos_valid_in, reached_end_in, result_ready_in,
        input  neigh_deq_out, pos_deq_out, id_out, dist_out, result_valid_out,
        input  busy_out, done_out
`ifdef NEIGHBOR_BEST_TRACK_EN
        , input best_id_out, best_dist_out, best_valid_out
`endif
    );
endinterface

// File: rtl/neighbor_dist_calc.sv
// neighbor_dist_calc: pops neighbor ids and positions, emits saturating squared distance to the query.
// Define NEIGHBOR_BEST_TRACK_EN to add tracking of the closest neighbor of each sweep.
module neighbor_dist_calc #(
    parameter int DIM    = 2,
    parameter int DIST_W = 64
) (
    input  logic                clk_in,
    input  logic                rst_in,
    neighbor_dist_calc_if.slave bus
);
    localparam int KW = DIM > 1 ? $clog2(DIM) : 1;
    localparam int SW = (DIST_W > 66 ? DIST_W : 66) + 1;

    typedef enum logic [1:0] {IDLE, NEIGH, POS, OUT} state_t;

    state_t               state_q, state_d;
    logic [DIM-1:0][31:0] q_q, q_d;
    logic [KW-1:0]        qidx_q, qidx_d, k_q, k_d;
    logic [31:0]          id_q, id_d;
    logic [DIST_W-1:0]    acc_q, acc_d;
    logic signed [32:0]   diff;
    logic signed [65:0]   sq;
    logic [SW-1:0]        sum;
    logic [DIST_W-1:0]    acc_sat;
`ifdef NEIGHBOR_BEST_TRACK_EN
    logic [31:0]          best_id_q, best_id_d;
    logic [DIST_W-1:0]    best_dist_q, best_dist_d;
    logic                 best_valid_q, best_valid_d;
`endif

    // 33-bit difference cannot overflow; its square is non-negative so the 66-bit product is safe unsigned
    assign diff    = $signed({bus.pos_in[31], bus.pos_in}) - $signed({q_q[k_q][31], q_q[k_q]});
    assign sq      = diff * diff;
    assign sum     = SW'(acc_q) + SW'($unsigned(sq));
    assign acc_sat = |(sum >> DIST_W) ? '1 : sum[DIST_W-1:0];

    assign bus.result_valid_out = state_q == OUT;
    assign bus.busy_out         = state_q != IDLE;
    assign bus.id_out           = id_q;
    assign bus.dist_out         = acc_q;
`ifdef NEIGHBOR_BEST_TRACK_EN
    assign bus.best_id_out      = best_id_q;
    assign bus.best_dist_out    = best_dist_q;
    assign bus.best_valid_out   = best_valid_q;
`endif

    always_comb begin
        state_d           = state_q;
        q_d               = q_q;
        qidx_d            = qidx_q;
        k_d               = k_q;
        id_d              = id_q;
        acc_d             = acc_q;
        bus.neigh_deq_out = 1'b0;
        bus.pos_deq_out   = 1'b0;
        bus.done_out      = 1'b0;
`ifdef NEIGHBOR_BEST_TRACK_EN
        best_id_d         = best_id_q;
        best_dist_d       = best_dist_q;
        best_valid_d      = best_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.query_valid_in) begin
                    q_d[qidx_q] = bus.query_in;
                    qidx_d      = qidx_q == KW'(DIM - 1) ? '0 : qidx_q + KW'(1);
                end
                if (bus.start_in) begin
                    state_d = NEIGH;
                    acc_d   = '0;
                    k_d     = '0;
`ifdef NEIGHBOR_BEST_TRACK_EN
                    best_dist_d  = '1;
                    best_valid_d = 1'b0;
`endif
                end
            end
            NEIGH: begin
                if (bus.neigh_valid_in) begin
                    bus.neigh_deq_out = 1'b1;
                    id_d              = bus.neigh_in;
                    state_d           = POS;
                end else if (bus.reached_end_in) begin
                    bus.done_out = 1'b1;
                    state_d      = IDLE;
                end
            end
            POS: begin
                if (bus.pos_valid_in) begin
                    bus.pos_deq_out = 1'b1;
                    acc_d           = acc_sat;
                    k_d             = k_q == KW'(DIM - 1) ? '0 : k_q + KW'(1);
                    state_d         = k_q == KW'(DIM - 1) ? OUT : POS;
                end
            end
            OUT: begin
                if (bus.result_ready_in) begin
                    acc_d   = '0;
                    state_d = NEIGH;
`ifdef NEIGHBOR_BEST_TRACK_EN
                    if (acc_q < best_dist_q) begin
                        best_id_d    = id_q;
                        best_dist_d  = acc_q;
                        best_valid_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            q_q          <= '0;
            qidx_q       <= '0;
            k_q          <= '0;
            id_q         <= '0;
            acc_q        <= '0;
`ifdef NEIGHBOR_BEST_TRACK_EN
            best_id_q    <= '0;
            best_dist_q  <= '0;
            best_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            qidx_q       <= qidx_d;
            k_q          <= k_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
`ifdef NEIGHBOR_BEST_TRACK_EN
            best_id_q    <= best_id_d;
            best_dist_q  <= best_dist_d;
            best_valid_q <= best_valid_d;
`endif
        end
    end
endmodule

// File: tb/tb_neighbor_dist_calc.sv
// tb_neighbor_dist_calc: FIFO-emulating bench with a plain-arithmetic distance model and scoreboard.
module tb_neighbor_dist_calc;
    localparam int DIM    = 2;
    localparam int DIST_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neighbor_dist_calc_if #(.DIST_W(DIST_W)) bus();
    neighbor_dist_calc #(.DIM(DIM), .DIST_W(DIST_W)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          nq[$];
    int          pq[$];
    int          exp_id[$];
    logic [63:0] exp_dist[$];
    int          got_id[$];
    logic [63:0] got_dist[$];
    int          done_cnt = 0;
    int          rdy_pct  = 100;
    int          pos_pct  = 100;
    bit          end_flag = 1'b1;
    bit          last_nd, last_pd;
    int          qv[DIM];

    function automatic logic [63:0] ref_dist(input int p0, input int p1);
        logic [127:0] s;
        int p[DIM];
        p[0] = p0;
        p[1] = p1;
        s = '0;
        for (int i = 0; i < DIM; i++) begin
            longint d;
            logic [63:0] a;
            d = longint'(p[i]) - longint'(qv[i]);
            a = d < 0 ? 64'(-d) : 64'(d);
            s += 128'(a) * 128'(a);
        end
        return s > 128'({64{1'b1}}) ? {64{1'b1}} : s[63:0];
    endfunction

    function automatic int rv();
        case ($urandom_range(3))
            0:       return int'($urandom_range(200)) - 100;
            1:       return int'($urandom);
            2:       return 32'h7FFFFFFF;
            default: return int'(32'h80000000);
        endcase
    endfunction

    // One clock: present FIFO heads, capture pops/results before the edge, pop after it
    task automatic cyc();
        bus.neigh_valid_in  = nq.size() > 0;
        bus.neigh_in        = nq.size() > 0 ? nq[0] : 0;
        bus.pos_valid_in    = pq.size() > 0 && ($urandom_range(99) < pos_pct);
        bus.pos_in          = pq.size() > 0 ? pq[0] : 0;
        bus.reached_end_in  = end_flag;
        bus.result_ready_in = $urandom_range(99) < rdy_pct;
        #1;
        last_nd = bus.neigh_deq_out;
        last_pd = bus.pos_deq_out;
        if (bus.result_valid_out && bus.result_ready_in) begin
            got_id.push_back(int'(bus.id_out));
            got_dist.push_back(bus.dist_out);
        end
        if (bus.done_out) done_cnt++;
        @(posedge clk);
        if (last_nd) void'(nq.pop_front());
        if (last_pd) void'(pq.pop_front());
        #1;
    endtask

    task automatic load_q(input int a, input int b);
        qv[0] = a;
        qv[1] = b;
        bus.query_valid_in = 1'b1;
        bus.query_in = a;
        cyc();
        bus.query_in = b;
        cyc();
        bus.query_valid_in = 1'b0;
    endtask

    task automatic push(input int id, input int p0, input int p1);
        nq.push_back(id);
        pq.push_back(p0);
        pq.push_back(p1);
        exp_id.push_back(id);
        exp_dist.push_back(ref_dist(p0, p1));
    endtask

    task automatic run_sweep(output bit ok, output int n);
        int d0;
        d0 = done_cnt;
        got_id.delete();
        got_dist.delete();
        bus.start_in = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        n = 0;
        while (n < 400 && done_cnt == d0) begin
            cyc();
            n++;
        end
        ok = done_cnt != d0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.neigh_valid_in = 1'b1;
        bus.pos_valid_in = 1'b1;
        bus.reached_end_in = 1'b1;
        bus.result_ready_in = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.result_valid_out, bus.busy_out, bus.done_out, bus.neigh_deq_out, bus.pos_deq_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00000", {bus.result_valid_out, bus.busy_out, bus.done_out, bus.neigh_deq_out, bus.pos_deq_out});
        end
        n_checks++;
        if (bus.id_out !== 32'd0 || bus.dist_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data got id=%0h dist=%0h want 0 0", bus.id_out, bus.dist_out);
        end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (bus.busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start got busy=%b want 0", bus.busy_out);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        load_q(3, 4);
        push(7, 0, 0);
        run_sweep(ok, n);
        n_checks++;
        if (!ok || got_id.size() != 1) begin
            n_fail++;
            $display("FAIL basic_done got done=%b results=%0d want 1 1", ok, got_id.size());
        end
        n_checks++;
        if (got_id.size() < 1 || got_id[0] !== 7 || got_dist[0] !== 64'd25) begin
            n_fail++;
            $display("FAIL basic_result got %0d want id=7 dist=25", got_id.size());
        end
        n_checks++;
        if (n !== DIM + 3) begin
            n_fail++;
            $display("FAIL basic_latency got %0d cycles want %0d", n, DIM + 3);
        end
        n_checks++;
        if (nq.size() != 0 || pq.size() != 0 || bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain got nq=%0d pq=%0d busy=%b done=%b want 0 0 0 0", nq.size(), pq.size(), bus.busy_out, bus.done_out);
        end
        exp_id.delete();
        exp_dist.delete();
    endtask

    task automatic test_wide();
        bit ok;
        int n;
        logic [63:0] want[3];
        want[0] = 64'd500;
        want[1] = 64'hFFFF_FFFE_0000_0001;
        want[2] = {64{1'b1}};
        for (int t = 0; t < 3; t++) begin
            if (t == 0) begin load_q(-5, 10); push(1, 5, -10); end
            if (t == 1) begin load_q(32'h7FFFFFFF, 0); push(2, int'(32'h80000000), 0); end
            if (t == 2) begin load_q(32'h7FFFFFFF, 32'h7FFFFFFF); push(3, int'(32'h80000000), int'(32'h80000000)); end
            run_sweep(ok, n);
            n_checks++;
            if (!ok || got_id.size() != 1 || got_dist[0] !== want[t] || got_dist[0] !== exp_dist[0] || got_id[0] !== exp_id[0]) begin
                n_fail++;
                $display("FAIL wide_%0d got dist=%0h count=%0d want %0h", t, got_dist.size() > 0 ? got_dist[0] : 64'd0, got_id.size(), want[t]);
            end
            exp_id.delete();
            exp_dist.delete();
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        load_q(1, 2);
        push(9, 3, 3);
        push(11, -1, 0);
        got_id.delete();
        got_dist.delete();
        d0 = done_cnt;
        rdy_pct = 0;
        bus.start_in = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        for (int i = 0; i < 20 && !bus.result_valid_out; i++) cyc();
        n_checks++;
        if (bus.result_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_valid got %b want 1", bus.result_valid_out);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_checks++;
            if (bus.result_valid_out !== 1'b1 || bus.id_out !== 32'd9 || bus.dist_out !== exp_dist[0] || last_nd || last_pd) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got v=%b id=%0d dist=%0h nd=%b pd=%b want 1 9 %0h 0 0", i, bus.result_valid_out, bus.id_out, bus.dist_out, last_nd, last_pd, exp_dist[0]);
            end
        end
        rdy_pct = 100;
        for (int i = 0; i < 40 && done_cnt == d0; i++) cyc();
        n_checks++;
        if (got_id.size() != 2 || done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL bp_count got results=%0d done=%0d want 2 1", got_id.size(), done_cnt - d0);
        end
        foreach (exp_id[i]) begin
            n_checks++;
            if (i >= got_id.size() || got_id[i] !== exp_id[i] || got_dist[i] !== exp_dist[i]) begin
                n_fail++;
                $display("FAIL bp_result_%0d want id=%0d dist=%0h", i, exp_id[i], exp_dist[i]);
            end
        end
        exp_id.delete();
        exp_dist.delete();
    endtask

    task automatic test_starvation();
        bit ok;
        int d0, n;
        load_q(2, -3);
        push(5, 10, 20);
        void'(pq.pop_back());
        got_id.delete();
        got_dist.delete();
        d0 = done_cnt;
        bus.start_in = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        for (int i = 0; i < 20 && pq.size() > 0; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            // start and query writes mid-sweep must be ignored
            bus.start_in = i == 1;
            bus.query_valid_in = i == 2;
            bus.query_in = 999;
            cyc();
            n_checks++;
            if (bus.busy_out !== 1'b1 || bus.result_valid_out !== 1'b0 || last_pd || last_nd) begin
                n_fail++;
                $display("FAIL starve_hold_%0d got busy=%b v=%b pd=%b nd=%b want 1 0 0 0", i, bus.busy_out, bus.result_valid_out, last_pd, last_nd);
            end
        end
        bus.start_in = 1'b0;
        bus.query_valid_in = 1'b0;
        pq.push_back(20);
        for (int i = 0; i < 40 && done_cnt == d0; i++) cyc();
        n_checks++;
        if (got_id.size() != 1 || got_id[0] !== 5 || got_dist[0] !== exp_dist[0]) begin
            n_fail++;
            $display("FAIL starve_result got count=%0d want id=5 dist=%0h", got_id.size(), exp_dist[0]);
        end
        exp_id.delete();
        exp_dist.delete();
        push(6, 0, 0);
        run_sweep(ok, n);
        n_checks++;
        if (!ok || got_id.size() != 1 || got_dist[0] !== exp_dist[0] || got_dist[0] !== 64'd13) begin
            n_fail++;
            $display("FAIL starve_query_kept got count=%0d want dist=13", got_id.size());
        end
        exp_id.delete();
        exp_dist.delete();
    endtask

    task automatic test_corner();
        bit ok;
        int d0, n;
        d0 = done_cnt;
        got_id.delete();
        bus.start_in = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        cyc();
        n_checks++;
        if (done_cnt != d0 + 1 || got_id.size() != 0 || bus.busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_list got done=%0d results=%0d busy=%b want 1 0 0", done_cnt - d0, got_id.size(), bus.busy_out);
        end
        cyc();
        n_checks++;
        if (done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL done_width got %0d pulses want 1", done_cnt - d0);
        end
        load_q(4, 4);
        push(8, 1, 2);
        void'(pq.pop_back());
        bus.start_in = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        for (int i = 0; i < 20 && pq.size() > 0; i++) cyc();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.result_valid_out, bus.busy_out, bus.done_out, bus.neigh_deq_out, bus.pos_deq_out} !== 5'b0 || bus.id_out !== 32'd0 || bus.dist_out !== 64'd0) begin
            n_fail++;
            $display("FAIL async_reset got flags=%b id=%0h dist=%0h want 0", {bus.result_valid_out, bus.busy_out, bus.done_out, bus.neigh_deq_out, bus.pos_deq_out}, bus.id_out, bus.dist_out);
        end
        rst = 1'b0;
        exp_id.delete();
        exp_dist.delete();
        qv[0] = 0;
        qv[1] = 0;
        push(3, 6, 8);
        run_sweep(ok, n);
        n_checks++;
        if (!ok || got_id.size() != 1 || got_id[0] !== 3 || got_dist[0] !== 64'd100) begin
            n_fail++;
            $display("FAIL post_reset_query got count=%0d want id=3 dist=100", got_id.size());
        end
        exp_id.delete();
        exp_dist.delete();
    endtask

    task automatic test_random();
        bit ok;
        int n;
        rdy_pct = 60;
        pos_pct = 70;
        for (int s = 0; s < 20; s++) begin
            load_q(rv(), rv());
            for (int j = 0; j < int'($urandom_range(4)); j++) push(int'($urandom), rv(), rv());
            run_sweep(ok, n);
            n_checks++;
            if (!ok || got_id.size() != exp_id.size() || nq.size() != 0 || pq.size() != 0) begin
                n_fail++;
                $display("FAIL rand_%0d_count got done=%b results=%0d want %0d", s, ok, got_id.size(), exp_id.size());
            end
            foreach (exp_id[i]) begin
                n_checks++;
                if (i >= got_id.size() || got_id[i] !== exp_id[i] || got_dist[i] !== exp_dist[i]) begin
                    n_fail++;
                    $display("FAIL rand_%0d_result_%0d want id=%0h dist=%0h", s, i, exp_id[i], exp_dist[i]);
                end
            end
`ifdef NEIGHBOR_BEST_TRACK_EN
            begin
                logic [63:0] bd;
                int bi;
                bit bv;
                bd = {64{1'b1}};
                bi = 0;
                bv = 1'b0;
                foreach (exp_dist[i]) if (exp_dist[i] < bd) begin bd = exp_dist[i]; bi = exp_id[i]; bv = 1'b1; end
                n_checks++;
                if (bus.best_valid_out !== bv || (bv && (bus.best_id_out !== bi || bus.best_dist_out !== bd))) begin
                    n_fail++;
                    $display("FAIL rand_%0d_best got v=%b id=%0h d=%0h want %b %0h %0h", s, bus.best_valid_out, bus.best_id_out, bus.best_dist_out, bv, bi, bd);
                end
            end
`endif
            exp_id.delete();
            exp_dist.delete();
        end
        rdy_pct = 100;
        pos_pct = 100;
    endtask

`ifdef NEIGHBOR_BEST_TRACK_EN
    task automatic test_best();
        bit ok;
        int n;
        load_q(0, 0);
        push(4, 5, 5);
        push(5, 4, 2);
        push(6, 2, 4);
        run_sweep(ok, n);
        n_checks++;
        if (!ok || bus.best_id_out !== 32'd5 || bus.best_dist_out !== 64'd20 || bus.best_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL best_track got id=%0d d=%0d v=%b want 5 20 1", bus.best_id_out, bus.best_dist_out, bus.best_valid_out);
        end
        exp_id.delete();
        exp_dist.delete();
        bus.start_in = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        n_checks++;
        if (bus.best_valid_out !== 1'b0 || bus.best_dist_out !== {64{1'b1}}) begin
            n_fail++;
            $display("FAIL best_restart got v=%b d=%0h want 0 all-ones", bus.best_valid_out, bus.best_dist_out);
        end
        cyc();
    endtask
`endif

    initial begin
        bus.start_in = 1'b0;
        bus.query_in = '0;
        bus.query_valid_in = 1'b0;
        bus.neigh_in = '0;
        bus.neigh_valid_in = 1'b0;
        bus.pos_in = '0;
        bus.pos_valid_in = 1'b0;
        bus.reached_end_in = 1'b0;
        bus.result_ready_in = 1'b0;
        test_reset();
        test_basic();
        test_wide();
        test_back_to_back();
        test_starvation();
        test_corner();
        test_random();
`ifdef NEIGHBOR_BEST_TRACK_EN
        test_best();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
